reg_file_2r_1w_param: RTL

Parametrised successor to the wavepool's fixed 8-entry, 64-bit, one-read/one-write register file.
- Generalised in depth and width.
- Two registered read ports and one byte-masked write port.
- Write-first bypass, per-entry valid tracking and a synchronous clear-all.
- Used by the wavepool and scheduling logic for per-wavefront state tables that need two concurrent lookups per cycle.

---
 rtl/reg_file_2r_1w_param.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/reg_file_2r_1w_param.sv
// ============================================================================
// Module   : reg_file_2r_1w_param
// Purpose  : DEPTH x WIDTH register file, two registered read ports, one
//            byte-masked write port, write-first bypass, valid bits, clear.
//            Optional per-byte parity enabled by REG_FILE_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_2r_1w_param #(
    parameter int WIDTH  = 64,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [WIDTH/8-1:0]   wr_mask,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 clear,
`ifdef REG_FILE_PARITY_EN
    input  logic                 parity_inject,
    output logic                 rd0_perr,
    output logic                 rd1_perr,
`endif
    input  logic                 rd0_en,
    input  logic [ADDR_W-1:0]    rd0_addr,
    output logic [WIDTH-1:0]     rd0_data,
    output logic                 rd0_vld,
    input  logic                 rd1_en,
    input  logic [ADDR_W-1:0]    rd1_addr,
    output logic [WIDTH-1:0]     rd1_data,
    output logic                 rd1_vld
);

    localparam int c_NUM_BYTES = WIDTH / 8;
    localparam int c_NUM_PORTS = 2;

    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [WIDTH-1:0]       mem_d [DEPTH];
    logic [DEPTH-1:0]       vld_q;
    logic [DEPTH-1:0]       vld_d;
    logic [WIDTH-1:0]       w_wr_base;
    logic [WIDTH-1:0]       w_wr_merged;

    logic                   w_rd_en   [c_NUM_PORTS];
    logic [ADDR_W-1:0]      w_rd_addr [c_NUM_PORTS];
    logic [WIDTH-1:0]       rd_data_q [c_NUM_PORTS];
    logic [WIDTH-1:0]       rd_data_d [c_NUM_PORTS];
    logic                   rd_vld_q  [c_NUM_PORTS];
    logic                   rd_vld_d  [c_NUM_PORTS];

    assign w_rd_en[0]   = rd0_en;
    assign w_rd_en[1]   = rd1_en;
    assign w_rd_addr[0] = rd0_addr;
    assign w_rd_addr[1] = rd1_addr;
    assign rd0_data     = rd_data_q[0];
    assign rd1_data     = rd_data_q[1];
    assign rd0_vld      = rd_vld_q[0];
    assign rd1_vld      = rd_vld_q[1];

    // Next state of the array: clear first, then the write merged on top.
    // Reads take mem_d/vld_d, which gives write-first bypass for free.
    always_comb begin
        w_wr_base   = '0;
        w_wr_merged = '0;
        vld_d       = clear ? '0 : vld_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = clear ? '0 : mem_q[i];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_addr == ADDR_W'(i)) begin
                w_wr_base = mem_d[i];
            end
        end
        for (int b = 0; b < c_NUM_BYTES; b++) begin
            w_wr_merged[8*b +: 8] = wr_mask[b] ? wr_data[8*b +: 8] : w_wr_base[8*b +: 8];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en && (wr_addr == ADDR_W'(i))) begin
                mem_d[i] = w_wr_merged;
                vld_d[i] = 1'b1;
            end
        end
        for (int p = 0; p < c_NUM_PORTS; p++) begin
            rd_data_d[p] = rd_data_q[p];
            rd_vld_d[p]  = rd_vld_q[p];
            if (w_rd_en[p]) begin
                rd_data_d[p] = '0;
                rd_vld_d[p]  = 1'b0;
                for (int i = 0; i < DEPTH; i++) begin
                    if (w_rd_addr[p] == ADDR_W'(i)) begin
                        rd_data_d[p] = mem_d[i];
                        rd_vld_d[p]  = vld_d[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            for (int p = 0; p < c_NUM_PORTS; p++) begin
                rd_data_q[p] <= '0;
                rd_vld_q[p]  <= 1'b0;
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            for (int p = 0; p < c_NUM_PORTS; p++) begin
                rd_data_q[p] <= rd_data_d[p];
                rd_vld_q[p]  <= rd_vld_d[p];
            end
        end
    end

`ifdef REG_FILE_PARITY_EN
    generate
        if (1) begin : g_parity
            logic [c_NUM_BYTES-1:0] par_q  [DEPTH];
            logic [c_NUM_BYTES-1:0] par_d  [DEPTH];
            logic                   perr_q [c_NUM_PORTS];
            logic                   perr_d [c_NUM_PORTS];

            function automatic logic [c_NUM_BYTES-1:0] byte_par(input logic [WIDTH-1:0] w);
                logic [c_NUM_BYTES-1:0] r;
                for (int b = 0; b < c_NUM_BYTES; b++) begin
                    r[b] = ^w[8*b +: 8];
                end
                return r;
            endfunction

            // Bypassed and cleared reads come from freshly computed state, so
            // only reads of untouched stored entries can flag an error.
            always_comb begin
                for (int i = 0; i < DEPTH; i++) begin
                    par_d[i] = clear ? '0 : par_q[i];
                    if (wr_en && (wr_addr == ADDR_W'(i))) begin
                        par_d[i] = byte_par(w_wr_merged)
                                 ^ {{(c_NUM_BYTES-1){1'b0}}, parity_inject};
                    end
                end
                for (int p = 0; p < c_NUM_PORTS; p++) begin
                    perr_d[p] = perr_q[p];
                    if (w_rd_en[p]) begin
                        perr_d[p] = 1'b0;
                        for (int i = 0; i < DEPTH; i++) begin
                            if ((w_rd_addr[p] == ADDR_W'(i)) && !clear
                                && !(wr_en && (wr_addr == ADDR_W'(i)))) begin
                                perr_d[p] = |(byte_par(mem_q[i]) ^ par_q[i]);
                            end
                        end
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        par_q[i] <= '0;
                    end
                    for (int p = 0; p < c_NUM_PORTS; p++) begin
                        perr_q[p] <= 1'b0;
                    end
                end else begin
                    for (int i = 0; i < DEPTH; i++) begin
                        par_q[i] <= par_d[i];
                    end
                    for (int p = 0; p < c_NUM_PORTS; p++) begin
                        perr_q[p] <= perr_d[p];
                    end
                end
            end

            assign rd0_perr = perr_q[0];
            assign rd1_perr = perr_q[1];
        end
    endgenerate
`endif

endmodule

`default_nettype wire
